// File: rtl/spi_flash_target.sv
// SPI serial-flash responder (mode 3) mapping opcodes 05/01/06/02/03/20 onto a byte-wide memory port.
// Define FLASH_TGT_BUSY_EN to hold WIP for BUSY_CYCLES clocks after program / write-status.
module spi_flash_target #(
  parameter int ADDR_W       = 24,
  parameter int SECTOR_BYTES = 4096,
  parameter int BUSY_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              CSbar,
  input  logic              DI,
  output logic              DO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        status
);

  localparam int SEC_W  = $clog2(SECTOR_BYTES);
  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
  localparam logic [SEC_W:0] ERASE_END = (SEC_W + 1)'(SECTOR_BYTES);

  typedef enum logic [3:0] {
    IDLE, OPCODE, ADDR, RD_DATA, STAT_OUT, STAT_IN, WR_DATA, ERASE, IGNORE
  } state_t;

  state_t              state;
  logic [1:0]          sck_sy, cs_sy, di_sy;
  logic                sck_q, cs_q;
  logic [7:0]          opcode, shift_sr, out_sr;
  logic [2:0]          bit_cnt;
  logic [15:0]         addr_sr;
  logic [1:0]          addr_byte;
  logic [ADDR_W-1:0]   addr_q;
  logic                wip, wel;
  logic [5:0]          user_bits;
  logic                erasing;
  logic [SEC_W:0]      erase_cnt;
  logic [BUSY_W-1:0]   busy_cnt;

  logic                cs_s, sck_rise, cs_fall, cs_rise, byte_done, addr_load;
  logic [7:0]          shift_in;
  logic [23:0]         addr_full;
  logic [ADDR_W-1:0]   addr_next;

  assign cs_s      = cs_sy[1];
  assign sck_rise  = sck_sy[1] & ~sck_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign shift_in  = {shift_sr[6:0], di_sy[1]};
  assign byte_done = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign addr_full = {addr_sr, shift_in};
  assign addr_next = addr_full[ADDR_W-1:0];

  // The first read byte must reach DO on the same edge that completes the address,
  // so the memory sees the incoming address combinationally for that one cycle.
  assign addr_load = byte_done && (state == ADDR) && (addr_byte == 2'd2) && (opcode == 8'h03);
  assign mem_addr  = addr_load ? addr_next : addr_q;

  assign status = {user_bits, wel, wip};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sy    <= 2'b11;
      cs_sy     <= 2'b11;
      di_sy     <= 2'b00;
      sck_q     <= 1'b1;
      cs_q      <= 1'b1;
      state     <= IDLE;
      opcode    <= 8'h00;
      shift_sr  <= 8'h00;
      out_sr    <= 8'h00;
      bit_cnt   <= 3'd0;
      addr_sr   <= 16'h0000;
      addr_byte <= 2'd0;
      addr_q    <= '0;
      DO        <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      wip       <= 1'b0;
      wel       <= 1'b0;
      user_bits <= 6'd0;
      erasing   <= 1'b0;
      erase_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      sck_sy <= {sck_sy[0], SCK};
      cs_sy  <= {cs_sy[0], CSbar};
      di_sy  <= {di_sy[0], DI};
      sck_q  <= sck_sy[1];
      cs_q   <= cs_s;
      mem_we <= 1'b0;

      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
        if (busy_cnt == BUSY_W'(1)) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end
      end

      // Erase sweep runs independently so the host can poll status while it proceeds.
      if (erasing) begin
        if (erase_cnt == ERASE_END) begin
          erasing <= 1'b0;
          wip     <= 1'b0;
          wel     <= 1'b0;
        end else begin
          mem_we    <= 1'b1;
          mem_wdata <= 8'hFF;
          addr_q    <= {addr_q[ADDR_W-1:SEC_W], erase_cnt[SEC_W-1:0]};
          erase_cnt <= erase_cnt + 1'b1;
        end
      end

      if (state == WR_DATA && mem_we)
        addr_q[7:0] <= addr_q[7:0] + 8'd1;

      if (cs_fall) begin
        bit_cnt   <= 3'd0;
        addr_byte <= 2'd0;
        state     <= OPCODE;
        DO        <= 1'b0;
      end else if (cs_rise) begin
        case (state)
          ERASE: begin
            erasing   <= 1'b1;
            erase_cnt <= '0;
            wip       <= 1'b1;
          end
          WR_DATA, STAT_IN: begin
`ifdef FLASH_TGT_BUSY_EN
            wip      <= 1'b1;
            busy_cnt <= BUSY_W'(BUSY_CYCLES);
`else
            wel <= 1'b0;
`endif
          end
          default: ;
        endcase
        state <= IDLE;
        DO    <= 1'b0;
      end else if (sck_rise && !cs_s) begin
        shift_sr <= shift_in;
        bit_cnt  <= bit_cnt + 1'b1;
        case (state)
          OPCODE: if (byte_done) begin
            opcode <= shift_in;
            if (wip && shift_in != 8'h05) begin
              state <= IGNORE;
            end else begin
              case (shift_in)
                8'h05: begin
                  state  <= STAT_OUT;
                  DO     <= status[7];
                  out_sr <= {status[6:0], 1'b0};
                end
                8'h06: begin
                  wel   <= 1'b1;
                  state <= IGNORE;
                end
                8'h01:        state <= wel ? STAT_IN : IGNORE;
                8'h02, 8'h20: state <= wel ? ADDR : IGNORE;
                8'h03:        state <= ADDR;
                default:      state <= IGNORE;
              endcase
            end
          end
          ADDR: if (byte_done) begin
            addr_sr   <= {addr_sr[7:0], shift_in};
            addr_byte <= addr_byte + 1'b1;
            if (addr_byte == 2'd2) begin
              addr_q <= addr_next;
              case (opcode)
                8'h03: begin
                  state  <= RD_DATA;
                  DO     <= mem_rdata[7];
                  out_sr <= {mem_rdata[6:0], 1'b0};
                  addr_q <= addr_next + 1'b1;
                end
                8'h02:   state <= WR_DATA;
                default: state <= ERASE;
              endcase
            end
          end
          RD_DATA: begin
            if (byte_done) begin
              DO     <= mem_rdata[7];
              out_sr <= {mem_rdata[6:0], 1'b0};
              addr_q <= addr_q + 1'b1;
            end else begin
              DO     <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
            end
          end
          STAT_OUT: begin
            if (byte_done) begin
              DO     <= status[7];
              out_sr <= {status[6:0], 1'b0};
            end else begin
              DO     <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
            end
          end
          STAT_IN: if (byte_done) user_bits <= shift_in[7:2];
          WR_DATA: if (byte_done) begin
            mem_we    <= 1'b1;
            mem_wdata <= shift_in;
          end
          IGNORE:  DO <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
